// File: rtl/wave_scheduler.sv
// Ping-pong bank sequencer for the wave_logic datapath: load idle pair, wait, swap on frame tick.
// Optional WAIT watchdog enabled by defining WAVE_TIMEOUT_EN.
module wave_scheduler #(
   parameter int unsigned DECAY_FRAMES = 8,
   parameter int unsigned DECAY_MUL    = 724,
   parameter int unsigned TIMEOUT      = 4095
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       vsync,
   input  logic       new_f_in,
   input  logic [4:0] freq_id1,
   input  logic [4:0] freq_id2,
   input  logic [3:0] bank_ready,
   output logic       load_strobe,
   output logic       load_bank,
   output logic [4:0] load_freq_a,
   output logic [4:0] load_freq_b,
   output logic       curr_w0,
   output logic [9:0] coeff,
   output logic       swap,
   output logic       busy,
   output logic       req_overwrite,
   output logic       calc_timeout
);

   typedef enum logic [1:0] {StIdle, StLoad, StWait, StSwap} state_e;

   state_e      state_q, state_d;
   logic        vsync_q;
   logic        frame_tick;
   logic        pend_valid_q, pend_valid_d;
   logic [4:0]  pend_a_q, pend_a_d;
   logic [4:0]  pend_b_q, pend_b_d;
   logic [1:0]  mask_q, mask_d;
   logic        curr_w0_q, curr_w0_d;
   logic [9:0]  coeff_q, coeff_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic        load_strobe_q, load_strobe_d;
   logic        load_bank_q, load_bank_d;
   logic [4:0]  load_freq_a_q, load_freq_a_d;
   logic [4:0]  load_freq_b_q, load_freq_b_d;
   logic        swap_q, swap_d;
   logic        busy_q, busy_d;
   logic        req_overwrite_q, req_overwrite_d;
   logic        consume;
   logic [1:0]  ready_pair;
   logic [19:0] decay_prod;
   logic        unused_prod;

`ifdef WAVE_TIMEOUT_EN
   logic [11:0] wait_cnt_q, wait_cnt_d;
   logic        calc_timeout_q, calc_timeout_d;
`endif

   assign frame_tick  = vsync & ~vsync_q;
   assign ready_pair  = load_bank_q ? bank_ready[3:2] : bank_ready[1:0];
   assign decay_prod  = 20'(coeff_q) * 20'(DECAY_MUL);
   assign unused_prod = ^decay_prod[9:0];

   always_comb begin
      state_d         = state_q;
      pend_valid_d    = pend_valid_q;
      pend_a_d        = pend_a_q;
      pend_b_d        = pend_b_q;
      mask_d          = mask_q;
      curr_w0_d       = curr_w0_q;
      coeff_d         = coeff_q;
      frame_cnt_d     = frame_cnt_q;
      load_strobe_d   = 1'b0;
      load_bank_d     = load_bank_q;
      load_freq_a_d   = load_freq_a_q;
      load_freq_b_d   = load_freq_b_q;
      swap_d          = 1'b0;
      req_overwrite_d = 1'b0;
      consume         = 1'b0;
`ifdef WAVE_TIMEOUT_EN
      wait_cnt_d      = wait_cnt_q;
      calc_timeout_d  = 1'b0;
`endif

      unique case (state_q)
         StIdle: begin
            if (pend_valid_q || new_f_in) begin
               consume = 1'b1;
               state_d = StLoad;
            end
         end
         StLoad: begin
            mask_d  = 2'b00;
            state_d = StWait;
`ifdef WAVE_TIMEOUT_EN
            wait_cnt_d = 12'd0;
`endif
         end
         StWait: begin
            mask_d = mask_q | ready_pair;
            if (&mask_d) state_d = StSwap;
`ifdef WAVE_TIMEOUT_EN
            else if (wait_cnt_q == 12'(TIMEOUT - 1)) begin
               calc_timeout_d = 1'b1;
               state_d        = StIdle;
            end else wait_cnt_d = wait_cnt_q + 12'd1;
`endif
         end
         StSwap: begin
            if (frame_tick) begin
               swap_d      = 1'b1;
               curr_w0_d   = ~curr_w0_q;
               coeff_d     = 10'h3FF;
               frame_cnt_d = 16'd0;
               if (pend_valid_q) begin
                  consume = 1'b1;
                  state_d = StLoad;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (frame_tick && !swap_d) begin
         if (frame_cnt_q == 16'(DECAY_FRAMES - 1)) begin
            frame_cnt_d = 16'd0;
            coeff_d     = decay_prod[19:10];
         end else begin
            frame_cnt_d = frame_cnt_q + 16'd1;
         end
      end

      // Target the pair that is idle after this edge; a same-cycle request bypasses pending.
      if (consume) begin
         pend_valid_d  = 1'b0;
         load_strobe_d = 1'b1;
         load_bank_d   = curr_w0_d;
         load_freq_a_d = new_f_in ? freq_id1 : pend_a_q;
         load_freq_b_d = new_f_in ? freq_id2 : pend_b_q;
      end else if (new_f_in) begin
         req_overwrite_d = pend_valid_q;
         pend_valid_d    = 1'b1;
         pend_a_d        = freq_id1;
         pend_b_d        = freq_id2;
      end

      busy_d = (state_d != StIdle) | swap_d;
   end

   always_ff @(posedge clock) begin
      vsync_q <= vsync;
      if (!reset) begin
         state_q         <= StIdle;
         pend_valid_q    <= 1'b0;
         pend_a_q        <= 5'h1F;
         pend_b_q        <= 5'h1F;
         mask_q          <= 2'b00;
         curr_w0_q       <= 1'b1;
         coeff_q         <= 10'h3FF;
         frame_cnt_q     <= 16'd0;
         load_strobe_q   <= 1'b0;
         load_bank_q     <= 1'b0;
         load_freq_a_q   <= 5'h1F;
         load_freq_b_q   <= 5'h1F;
         swap_q          <= 1'b0;
         busy_q          <= 1'b0;
         req_overwrite_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         pend_valid_q    <= pend_valid_d;
         pend_a_q        <= pend_a_d;
         pend_b_q        <= pend_b_d;
         mask_q          <= mask_d;
         curr_w0_q       <= curr_w0_d;
         coeff_q         <= coeff_d;
         frame_cnt_q     <= frame_cnt_d;
         load_strobe_q   <= load_strobe_d;
         load_bank_q     <= load_bank_d;
         load_freq_a_q   <= load_freq_a_d;
         load_freq_b_q   <= load_freq_b_d;
         swap_q          <= swap_d;
         busy_q          <= busy_d;
         req_overwrite_q <= req_overwrite_d;
      end
   end

`ifdef WAVE_TIMEOUT_EN
   always_ff @(posedge clock) begin
      if (!reset) begin
         wait_cnt_q     <= 12'd0;
         calc_timeout_q <= 1'b0;
      end else begin
         wait_cnt_q     <= wait_cnt_d;
         calc_timeout_q <= calc_timeout_d;
      end
   end
   assign calc_timeout = calc_timeout_q;
`else
   logic unused_timeout;
   assign unused_timeout = ^32'(TIMEOUT);
   assign calc_timeout   = 1'b0;
`endif

   assign load_strobe   = load_strobe_q;
   assign load_bank     = load_bank_q;
   assign load_freq_a   = load_freq_a_q;
   assign load_freq_b   = load_freq_b_q;
   assign curr_w0       = curr_w0_q;
   assign coeff         = coeff_q;
   assign swap          = swap_q;
   assign busy          = busy_q;
   assign req_overwrite = req_overwrite_q;

endmodule

// File: tb/tb_wave_scheduler.sv
// Self-checking bench for wave_scheduler: transaction-level reference model plus directed scenarios.
module tb_wave_scheduler;

   localparam int DF = 8;
   localparam int DM = 724;
   localparam int TO = 100;
`ifdef WAVE_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       vsync = 1'b0;
   logic       new_f_in = 1'b0;
   logic [4:0] freq_id1 = 5'd0;
   logic [4:0] freq_id2 = 5'h1F;
   logic [3:0] bank_ready = 4'd0;
   logic       load_strobe, load_bank, curr_w0, swap, busy, req_overwrite, calc_timeout;
   logic [4:0] load_freq_a, load_freq_b;
   logic [9:0] coeff;

   always #5 clock = ~clock;

   wave_scheduler #(
      .DECAY_FRAMES(DF),
      .DECAY_MUL   (DM),
      .TIMEOUT     (TO)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .vsync        (vsync),
      .new_f_in     (new_f_in),
      .freq_id1     (freq_id1),
      .freq_id2     (freq_id2),
      .bank_ready   (bank_ready),
      .load_strobe  (load_strobe),
      .load_bank    (load_bank),
      .load_freq_a  (load_freq_a),
      .load_freq_b  (load_freq_b),
      .curr_w0      (curr_w0),
      .coeff        (coeff),
      .swap         (swap),
      .busy         (busy),
      .req_overwrite(req_overwrite),
      .calc_timeout (calc_timeout)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one job at a time (idle / loading / computing / awaiting frame).
   localparam int JobNone = 0, JobLoad = 1, JobCalc = 2, JobFrame = 3;
   int  job = JobNone;
   bit  vs_prev = 1'b0;
   bit  pv = 1'b0;
   int  pa = 31, pb = 31;
   int  got = 0, wcycles = 0, ticks = 0;
   bit  active0 = 1'b1;
   int  m_coeff = 1023;
   bit  e_ls = 0, e_lb = 0, e_sw = 0, e_busy = 0, e_ow = 0, e_to = 0;
   int  e_fa = 31, e_fb = 31;
   bit  cmp_en = 1'b0;

   always @(posedge clock) begin : model
      bit tick, take;
      int rdy;
      tick    = vsync && !vs_prev;
      vs_prev = vsync;
      e_ls = 0; e_sw = 0; e_ow = 0; e_to = 0;
      if (!reset) begin
         job = JobNone; pv = 0; active0 = 1; m_coeff = 1023; ticks = 0;
         e_lb = 0; e_fa = 31; e_fb = 31; e_busy = 0;
      end else begin
         take = (job == JobNone && (pv || new_f_in)) || (job == JobFrame && tick && pv);
         if (job == JobFrame && tick) begin
            active0 = !active0; m_coeff = 1023; ticks = 0; e_sw = 1;
            job = take ? JobLoad : JobNone;
         end else begin
            if (tick) begin
               ticks++;
               if (ticks == DF) begin
                  ticks = 0;
                  m_coeff = (m_coeff * DM) / 1024;
               end
            end
            if (job == JobNone && take) job = JobLoad;
            else if (job == JobLoad) begin
               job = JobCalc; got = 0; wcycles = 0;
            end else if (job == JobCalc) begin
               rdy = e_lb ? int'(bank_ready[3:2]) : int'(bank_ready[1:0]);
               got = got | rdy;
               wcycles++;
               if (got == 3) job = JobFrame;
               else if (TIMEOUT_EN && wcycles == TO) begin
                  job = JobNone; e_to = 1;
               end
            end
         end
         if (take) begin
            e_ls = 1; e_lb = active0;
            e_fa = new_f_in ? int'(freq_id1) : pa;
            e_fb = new_f_in ? int'(freq_id2) : pb;
            pv = 0;
         end else if (new_f_in) begin
            e_ow = pv; pv = 1; pa = int'(freq_id1); pb = int'(freq_id2);
         end
         e_busy = (job != JobNone) || e_sw;
      end
      cmp_en = 1'b1;
   end

   int ls_total = 0;
   int ow_total = 0;

   always @(negedge clock) begin
      if (cmp_en) begin
         chk("load_strobe", {31'd0, load_strobe}, {31'd0, e_ls});
         chk("load_bank", {31'd0, load_bank}, {31'd0, e_lb});
         chk("load_freq_a", {27'd0, load_freq_a}, e_fa);
         chk("load_freq_b", {27'd0, load_freq_b}, e_fb);
         chk("curr_w0", {31'd0, curr_w0}, {31'd0, active0});
         chk("coeff", {22'd0, coeff}, m_coeff);
         chk("swap", {31'd0, swap}, {31'd0, e_sw});
         chk("busy", {31'd0, busy}, {31'd0, e_busy});
         chk("req_overwrite", {31'd0, req_overwrite}, {31'd0, e_ow});
         chk("calc_timeout", {31'd0, calc_timeout}, {31'd0, e_to});
         if (load_strobe === 1'b1) ls_total++;
         if (req_overwrite === 1'b1) ow_total++;
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic req(input logic [4:0] a, input logic [4:0] b);
      new_f_in = 1'b1; freq_id1 = a; freq_id2 = b;
      cyc(1);
      new_f_in = 1'b0;
   endtask

   task automatic rdy(input logic [3:0] m);
      bank_ready = m;
      cyc(1);
      bank_ready = 4'd0;
   endtask

   task automatic vs_edge();
      vsync = 1'b1;
      cyc(1);
      vsync = 1'b0;
      cyc(1);
   endtask

   initial begin
      int ow_base, ls_base;
      reset = 1'b0;
      cyc(3);
      chk("rst_curr_w0", {31'd0, curr_w0}, 32'd1);
      chk("rst_coeff", {22'd0, coeff}, 32'h3FF);
      chk("rst_freq_a", {27'd0, load_freq_a}, 32'h1F);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      reset = 1'b1;
      cyc(1);

      // First job: 3/31 into bank 1, ready arrives piecemeal, two requests queue up meanwhile.
      ow_base = ow_total;
      req(5'd3, 5'd31);
      chk("t1_strobe", {31'd0, load_strobe}, 32'd1);
      chk("t1_bank", {31'd0, load_bank}, 32'd1);
      chk("t1_fa", {27'd0, load_freq_a}, 32'd3);
      chk("t1_fb", {27'd0, load_freq_b}, 32'd31);
      cyc(1);
      rdy(4'b0100);
      rdy(4'b0011);
      req(5'd5, 5'd31);
      req(5'd9, 5'd12);
      cyc(1);
      chk("t1_ow_once", ow_total - ow_base, 32'd1);
      chk("t1_still_w0", {31'd0, curr_w0}, 32'd1);
      rdy(4'b1000);
      cyc(2);
      chk("t1_busy_swap", {31'd0, busy}, 32'd1);
      vsync = 1'b1;
      cyc(1);
      chk("t1_swap", {31'd0, swap}, 32'd1);
      chk("t1_w0", {31'd0, curr_w0}, 32'd0);
      chk("t1_coeff", {22'd0, coeff}, 32'h3FF);
      chk("t2_strobe", {31'd0, load_strobe}, 32'd1);
      chk("t2_bank", {31'd0, load_bank}, 32'd0);
      chk("t2_fa", {27'd0, load_freq_a}, 32'd9);
      chk("t2_fb", {27'd0, load_freq_b}, 32'd12);
      vsync = 1'b0;
      cyc(1);

      // Second job on bank 0: wrong-pair ready ignored, both bits in one cycle.
      rdy(4'b1100);
      rdy(4'b0011);
      vsync = 1'b1;
      cyc(1);
      chk("t2_swap", {31'd0, swap}, 32'd1);
      chk("t2_busy_swap", {31'd0, busy}, 32'd1);
      chk("t2_w0", {31'd0, curr_w0}, 32'd1);
      vsync = 1'b0;
      cyc(1);
      chk("t2_idle", {31'd0, busy}, 32'd0);

      // Decay with no swaps, down to zero.
      repeat (7) vs_edge();
      chk("dec_7", {22'd0, coeff}, 32'h3FF);
      vs_edge();
      chk("dec_8", {22'd0, coeff}, 32'h2D3);
      repeat (8) vs_edge();
      chk("dec_16", {22'd0, coeff}, 32'h1FF);
      repeat (15 * 8) vs_edge();
      chk("dec_one", {22'd0, coeff}, 32'd1);
      repeat (8) vs_edge();
      chk("dec_zero", {22'd0, coeff}, 32'd0);
      repeat (8) vs_edge();
      chk("dec_hold", {22'd0, coeff}, 32'd0);

      // Reset in WAIT with a pending request: nothing loads afterwards.
      req(5'd4, 5'd5);
      cyc(1);
      req(5'd6, 5'd7);
      cyc(1);
      reset = 1'b0;
      cyc(1);
      reset = 1'b1;
      ls_base = ls_total;
      chk("rst2_busy", {31'd0, busy}, 32'd0);
      chk("rst2_w0", {31'd0, curr_w0}, 32'd1);
      chk("rst2_coeff", {22'd0, coeff}, 32'h3FF);
      cyc(6);
      chk("rst2_no_load", ls_total - ls_base, 32'd0);

`ifdef WAVE_TIMEOUT_EN
      req(5'd8, 5'd31);
      cyc(1);
      cyc(99);
      cyc(1);
      chk("to_pulse", {31'd0, calc_timeout}, 32'd1);
      chk("to_w0", {31'd0, curr_w0}, 32'd1);
      chk("to_idle", {31'd0, busy}, 32'd0);
      cyc(4);
`endif

      cyc(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
